// File: rtl/medfilt_out_fifo.sv
// Output FIFO stage behind the 3-tap median filter: drops pipeline-fill samples, buffers the rest, flags overflow.
// Optional drop statistics counter enabled by defining MEDFILT_FIFO_STATS_EN.
module medfilt_out_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int PRIME = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DW-1:0]              din,
  input  logic                       din_valid,
  input  logic                       flush,
  input  logic                       clr_ovf,
  output logic [DW-1:0]              dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [$clog2(DEPTH):0]     level,
`ifdef MEDFILT_FIFO_STATS_EN
  output logic [15:0]                drop_cnt,
`endif
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [3:0]    PRIME_C = 4'(PRIME);
  localparam logic [LW-1:0] FULL_C  = LW'(DEPTH);

  typedef enum logic {
    ST_PRIME  = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // A zero-length prime skips the discard phase entirely.
  localparam state_t INIT_ST = (PRIME == 0) ? ST_STREAM : ST_PRIME;

  state_t          state_r, state_s;
  logic [3:0]      prime_cnt_r, prime_cnt_s;
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]   level_r, level_s;
  logic            overflow_r;
  logic            empty_s, full_s, pop_s, wr_s, drop_s;
  logic [DW-1:0]   mem [DEPTH];

  assign empty_s = (level_r == {LW{1'b0}});
  assign full_s  = (level_r == FULL_C);
  assign pop_s   = !flush && !empty_s && dout_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_s    = !flush && (state_r == ST_STREAM) && din_valid && (!full_s || pop_s);
  assign drop_s  = !flush && (state_r == ST_STREAM) && din_valid && full_s && !pop_s;

  // Next-state logic for the priming/streaming controller.
  always_comb begin
    state_s     = state_r;
    prime_cnt_s = prime_cnt_r;
    if (flush) begin
      state_s     = INIT_ST;
      prime_cnt_s = 4'd0;
    end else begin
      case (state_r)
        ST_PRIME: begin
          if (din_valid) begin
            prime_cnt_s = prime_cnt_r + 4'd1;
            if ((prime_cnt_r + 4'd1) == PRIME_C) begin
              state_s = ST_STREAM;
            end else begin
              state_s = ST_PRIME;
            end
          end else begin
            state_s = ST_PRIME;
          end
        end
        ST_STREAM: state_s = ST_STREAM;
        default:   state_s = INIT_ST;
      endcase
    end
  end

  // Next occupancy from the write/pop pair.
  always_comb begin
    level_s = level_r;
    case ({wr_s, pop_s})
      2'b10:   level_s = level_r + LW'(1);
      2'b01:   level_s = level_r - LW'(1);
      default: level_s = level_r;
    endcase
  end

  // Controller, pointer, occupancy and sticky overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= INIT_ST;
      prime_cnt_r <= 4'd0;
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      level_r     <= {LW{1'b0}};
      overflow_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      prime_cnt_r <= prime_cnt_s;
      if (flush) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
        level_r  <= {LW{1'b0}};
      end else begin
        if (wr_s) begin
          wr_ptr_r <= wr_ptr_r + AW'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + AW'(1);
        end
        level_r <= level_s;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Sample storage, deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem[wr_ptr_r] <= din;
    end
  end

`ifdef MEDFILT_FIFO_STATS_EN
  logic [15:0] drop_cnt_r;

  // Saturating count of samples lost to overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_r <= 16'd0;
    end else if (clr_ovf) begin
      drop_cnt_r <= drop_s ? 16'd1 : 16'd0;
    end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
      drop_cnt_r <= drop_cnt_r + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_r;
`endif

  assign dout       = empty_s ? {DW{1'b0}} : mem[rd_ptr_r];
  assign dout_valid = !empty_s;
  assign level      = level_r;
  assign overflow   = overflow_r;

endmodule

// File: doc/medfilt_out_fifo.md
# medfilt_out_fifo

Output buffer stage directly downstream of the 3-tap median filter. It takes the filter's registered 8-bit median stream, one sample per clock when qualified, and discards the pipeline-fill samples produced after reset or restart. It buffers the remaining samples in a small synchronous FIFO and presents them to the next consumer over a valid/ready handshake. It also flags samples lost to overflow.

## Interface
- DW, 8, sample width in bits (matches filter output width)
- DEPTH, 8, FIFO entries; power of two, at least 2
- PRIME, 4, samples discarded after reset/flush (filter fill latency: 3 window registers + 1 output register); legal range 0..15

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- din  in  DW  median filter output sample
- din_valid  in  1  din carries a new sample this cycle
- flush  in  1  synchronous restart: empty FIFO, re-enter priming
- clr_ovf  in  1  clear sticky overflow (and drop counter when compiled in)
- dout  out  DW  FIFO head sample; 0 when empty
- dout_valid  out  1  FIFO non-empty
- dout_ready  in  1  consumer accepts head this cycle
- level  out  $clog2(DEPTH)+1  current entry count, 0..DEPTH
- overflow  out  1  sticky: at least one sample dropped because FIFO full

## Operation
- Two-state control FSM: PRIME and STREAM.
  - Reset or flush enters PRIME with prime counter = 0.
  - If PRIME = 0, enters STREAM directly.
- PRIME state:
  - Each din_valid cycle increments the prime counter; the sample is discarded and not written.
  - On the cycle the PRIME-th sample is discarded, the next state is STREAM.
  - Reads still proceed in this state; the FIFO is empty after reset/flush, so there is nothing to read.
- STREAM state:
  - din_valid with the FIFO not full writes din at wr_ptr, then wr_ptr increments modulo DEPTH.
- Read:
  - dout_valid && dout_ready pops the head; rd_ptr increments modulo DEPTH.
  - dout_ready while empty has no effect.
- Full and simultaneous pop:
  - If level == DEPTH and a pop occurs in the same cycle, the write is accepted. Level is unchanged and there is no overflow.
  - If level == DEPTH with no pop, the sample is dropped and overflow sets.
- Simultaneous write and pop at any level: level is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally. level is a separate counter, which disambiguates full from empty.
- flush:
  - Highest priority: the write and pop in that cycle are ignored.
  - Next cycle: pointers 0, level 0, state PRIME.
  - overflow is NOT cleared by flush.
- clr_ovf clears overflow. If a drop happens in the same cycle, set wins and overflow = 1.
- dout = mem[rd_ptr] when level != 0, else 0. FIFO storage itself is not reset.
- Reset values: dout 0, dout_valid 0, level 0, overflow 0, state PRIME (or STREAM if PRIME = 0), pointers 0.

## Timing
- Write to visibility: a sample written at edge N appears on dout with dout_valid = 1 after edge N (first-word latency 1 cycle). Output is combinational from storage; there is no extra output register.
- Pop at edge N: the next head is presented after edge N.
- First buffered sample after reset is the (PRIME+1)-th din_valid sample.
- Sustained throughput is 1 sample/cycle in and out with no bubbles.
- rst_n assertion mid-operation immediately forces all reset values, asynchronously. Deassertion is synchronised externally; the first active edge after deassertion is a normal PRIME cycle.

## Configuration
- MEDFILT_FIFO_STATS_EN defined:
  - Adds output port drop_cnt [15:0].
  - Counts samples dropped due to overflow; priming discards are not counted.
  - Saturates at 16'hFFFF, resets to 0, and is cleared by clr_ovf. A drop in the same cycle as clr_ovf yields 1.
  - flush does not clear it.
- MEDFILT_FIFO_STATS_EN undefined: drop_cnt port and counter are absent; all other behaviour is identical.

## Test plan
- Priming: after reset, feed din_valid samples 0x10..0x1F on consecutive cycles with dout_ready = 1 → 0x10..0x13 discarded; dout sequence 0x14..0x1F; dout_valid first high one cycle after 0x14 is presented.
- Fill/overflow: dout_ready = 0, stream 12 samples after priming → level = 8; the first 8 samples are kept; overflow = 1; drop_cnt = 4 (with macro); then drain → exactly the first 8 samples, in order.
- Full plus simultaneous pop: at level 8, assert din_valid and dout_ready in the same cycle → level stays 8, no overflow, new sample appears at the tail.
- Wrap-around: 20 write/pop cycles at level 3 with DEPTH = 8 → output order preserved across pointer wrap; level constant at 3.
- Flush and clr_ovf priority: flush while level = 5 and overflow = 1 → next cycle level 0, dout 0, overflow still 1, next 4 samples discarded. clr_ovf asserted in the same cycle as a drop → overflow stays 1.
- Async reset mid-stream: drop rst_n between clock edges at level 6 → dout_valid, level and overflow go to 0 immediately; after release, priming restarts (PRIME = 0 build: the first sample is buffered).
